vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Generates the 640x480@60Hz raster timing that drives every pixel-render stage.
//  - Produces DrawX/DrawY, which feed the ROM-addressing renderers (background, sprites).
//  - Produces hs/vs/blank, delayed by a programmable pipeline depth so they stay aligned
//    with renderer colour outputs (ROM read + output register).
//  - Also emits frame/line strobes for game-logic sequencing.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   horizontal sync width (pixels)
//  H_BP      48   horizontal back porch (pixels); H_TOTAL = sum = 800
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vertical sync width (lines)
//  V_BP      33   vertical back porch (lines); V_TOTAL = sum = 525
//  PIPE_DLY  2    cycles of delay on hs/vs/blank relative to DrawX/DrawY (0..4)
// PORTS
//  vga_clk      in   1   pixel clock (25 MHz)
//  reset_n      in   1   synchronous, active-low reset
//  DrawX        out  10  current horizontal count, 0..H_TOTAL-1
//  DrawY        out  10  current vertical count, 0..V_TOTAL-1
//  hs           out  1   horizontal sync, active low, delayed PIPE_DLY
//  vs           out  1   vertical sync, active low, delayed PIPE_DLY
//  blank        out  1   1 = active display region (pixel shown), 0 = blanking; delayed PIPE_DLY
//  frame_start  out  1   1-cycle pulse while DrawX==0 && DrawY==0 (undelayed)
//  line_start   out  1   1-cycle pulse while DrawX==0 (undelayed)
// BEHAVIOUR
//  Reset (reset_n=0 sampled at posedge; takes effect at that same edge; valid mid-frame):
//  - Counters go to 0.
//  - Every hs/vs/blank delay stage is loaded with the idle values hs=1, vs=1, blank=0.
//  - frame_start/line_start are held 0 throughout reset.
//  Counters (10-bit registers; DrawX/DrawY are these registers directly):
//  - hc increments each cycle; at hc==H_TOTAL-1, hc wraps to 0 and vc increments.
//  - At vc==V_TOTAL-1 with hc==H_TOTAL-1, both wrap to 0.
//  - H_TOTAL and V_TOTAL must each be <= 1024 (elaboration-time check).
//  Raw decode (combinational from hc/vc, cycle 0):
//  - hs_r = 0 iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (656..751).
//  - vs_r = 0 iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC (490..491).
//    vs_r is purely line-based; no half-line offset.
//  - blank_r = (hc < H_ACTIVE) && (vc < V_ACTIVE).
//  Delay line:
//  - hs/vs/blank = raw values passed through a PIPE_DLY-deep register chain.
//  - PIPE_DLY=0: outputs are the raw decode, same cycle as DrawX/DrawY.
//  - PIPE_DLY=N: an output reflects the coordinate presented N cycles earlier.
//  Strobes:
//  - frame_start/line_start decode directly from hc/vc; they are not delayed.
//  - They are forced 0 while reset_n=0.
//  - After reset release, the first cycle has DrawX=0, DrawY=0, frame_start=1, line_start=1.
//  Frame period: exactly H_TOTAL*V_TOTAL = 420000 cycles. No other state; no FSM beyond the counters.
// TESTING
//  1 Hold reset_n=0 for 5 cycles -> DrawX=0, DrawY=0, hs=1, vs=1, blank=0, strobes=0.
//    Release -> frame_start=1 on the first cycle.
//  2 Run from reset; at DrawX=799 on DrawY=0 -> next cycle DrawX=0, DrawY=1, line_start=1.
//  3 PIPE_DLY=2 on line 0 -> hs falls 2 cycles after DrawX=656 and rises 2 cycles after DrawX=752.
//    hs low width = 96 cycles.
//  4 Check vs across frame -> vs low only for lines 490..491 (2*800=1600 cycles, shifted by PIPE_DLY).
//    blank=0 on all lines >= 480.
//  5 At DrawX=799, DrawY=524 -> wrap to (0,0), frame_start=1.
//    Successive frame_start pulses are exactly 420000 cycles apart.
//  6 Assert reset_n=0 for 1 cycle at (300,200) -> next cycle DrawX=0, DrawY=0, hs=1, vs=1, blank=0.
//    Delay line is flushed; first blank=1 appears PIPE_DLY cycles after release.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480@60Hz raster timing: pixel/line counters, sync/blank decode
// with a programmable alignment delay, and frame/line strobes.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_DLY = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       frame_start,
  output logic       line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // {hs, vs, blank} as seen while idle / in reset
  localparam logic [2:0] IDLE = 3'b110;

  if (H_TOTAL > 1024) begin : g_bad_h
    $error("H_TOTAL must not exceed 1024");
  end
  if (V_TOTAL > 1024) begin : g_bad_v
    $error("V_TOTAL must not exceed 1024");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_bad_dly
    $error("PIPE_DLY must be in 0..4");
  end

  logic [9:0]  hc_q;
  logic [9:0]  hc_d;
  logic [9:0]  vc_q;
  logic [9:0]  vc_d;
  logic        h_end;
  logic        v_end;
  logic [31:0] hx;
  logic [31:0] vy;
  logic        hs_r;
  logic        vs_r;
  logic        blank_r;
  logic [2:0]  raw;

  // Next pixel/line position; reset parks the raster at (0,0)
  always_comb begin
    h_end = (hc_q == H_LAST);
    v_end = (vc_q == V_LAST);
    hc_d  = hc_q + 10'd1;
    vc_d  = vc_q;
    if (h_end) begin
      hc_d = '0;
      vc_d = v_end ? '0 : vc_q + 10'd1;
    end
    if (!reset_n) begin
      hc_d = '0;
      vc_d = '0;
    end
  end

  // Raster counter registers
  always_ff @(posedge vga_clk) begin
    hc_q <= hc_d;
    vc_q <= vc_d;
  end

  assign DrawX = hc_q;
  assign DrawY = vc_q;

  // Undelayed sync/blank decode of the current coordinate
  always_comb begin
    hx      = {22'd0, hc_q};
    vy      = {22'd0, vc_q};
    hs_r    = !((hx >= HS_BEG) && (hx < HS_END));
    vs_r    = !((vy >= VS_BEG) && (vy < VS_END));
    blank_r = (hx < H_ACTIVE) && (vy < V_ACTIVE);
  end

  assign raw = {hs_r, vs_r, blank_r};

  // Strobes track the counters directly and stay quiet in reset
  assign line_start  = reset_n && (hc_q == '0);
  assign frame_start = line_start && (vc_q == '0);

  if (PIPE_DLY == 0) begin : g_nodly
    assign {hs, vs, blank} = raw;
  end else begin : g_dly
    logic [2:0] dly_q [PIPE_DLY];
    logic [2:0] dly_d [PIPE_DLY];

    // Shift raw decode along; reset flushes every stage to idle
    always_comb begin
      dly_d[0] = raw;
      for (int i = 1; i < PIPE_DLY; i++) begin
        dly_d[i] = dly_q[i-1];
      end
      if (!reset_n) begin
        for (int i = 0; i < PIPE_DLY; i++) begin
          dly_d[i] = IDLE;
        end
      end
    end

    // Alignment delay registers
    always_ff @(posedge vga_clk) begin
      for (int i = 0; i < PIPE_DLY; i++) begin
        dly_q[i] <= dly_d[i];
      end
    end

    assign {hs, vs, blank} = dly_q[PIPE_DLY-1];
  end

endmodule
